// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multi-cycle control sequencer.
// Holds the state encodings, the opcode/func constants decoded in sID/sEXE/sMEM,
// the err_code values and a legality helper used by the optional illegal-opcode trap.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'b000,
    S_ID   = 3'b001,
    S_EXE  = 3'b010,
    S_MEM  = 3'b011,
    S_WB   = 3'b100,
    S_HALT = 3'b101,
    S_ERR  = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_ILLEGAL = 2'b10
  } err_code_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] FUNC_JR = 6'b001000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_BGTZ = 6'b000111;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_HALT = 6'b111111;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_R, OP_ADDI, OP_SLTI, OP_ORI, OP_LW, OP_SW,
      OP_BEQ, OP_BNE, OP_BGTZ, OP_J, OP_JAL, OP_HALT: is_legal_op = 1'b1;
      default:                                        is_legal_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// mc_wait_timer: consecutive not-ready cycle counter for the sequencer's wait states.
// Ports:
//   CLK, nRST  clock (rising edge) and asynchronous active-low reset
//   inc        a wait cycle is happening (memory not ready)
//   clear      the sequencer is changing state this cycle; counter returns to 0
//   hold       freeze the count (external stall)
//   expired    this wait cycle is the (2^TIMEOUT_W-1)-th in a row; the sequencer
//              must take the error path on the coming edge
module mc_wait_timer #(
  parameter int TIMEOUT_W = 4
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc,
  input  logic clear,
  input  logic hold,
  output logic expired
);

  // Count value at the start of the last tolerated wait cycle.
  localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_W'((1 << TIMEOUT_W) - 2);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (!hold && inc) begin
      count <= count + 1'b1;
    end
  end

  // A ready input removes inc, so a ready arriving in the final cycle wins.
  assign expired = inc && !hold && (count == LAST);

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle IF/ID/EXE/MEM/WB control sequencer with
// variable-latency fetch/data handshakes, external stall and wait timeout.
// Build option: define MC_SEQ_TRAP_EN to send illegal opcodes in sID to sERR
// with err_code 10; otherwise they take the default sID->sEXE->sWB path.
// Ports:
//   CLK, nRST            clock and asynchronous active-low reset
//   opCode, func         current IR fields
//   imem_ready           fetch data valid (completes sIF)
//   dmem_ready           data access complete (completes sMEM)
//   stall                hold state/counter and suppress commit strobes
//   state                current state encoding
//   imem_req, IRWrite, pcWrite, RegWr   active-high strobes
//   nRD, nWR             active-low data read/write
//   halted, err          sticky status (sHALT / sERR)
//   err_code             01 timeout, 10 illegal opcode
// Handshake: a wait state is left on the edge that ends a cycle in which its
// ready input is high and stall is low; strobes are combinational and valid in
// the cycle before the edge that commits them.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int TIMEOUT_W = 4,
  parameter int OP_W      = 6,
  parameter int FUNC_W    = 6
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [OP_W-1:0]   opCode,
  input  logic [FUNC_W-1:0] func,
  input  logic              imem_ready,
  input  logic              dmem_ready,
  input  logic              stall,
  output logic [2:0]        state,
  output logic              imem_req,
  output logic              IRWrite,
  output logic              pcWrite,
  output logic              RegWr,
  output logic              nRD,
  output logic              nWR,
  output logic              halted,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t    state_q, next_state;
  err_code_t err_q, next_err;
  logic [5:0] op, fn;
  logic is_jump, is_branch, is_lw, is_sw, trap_illegal;
  logic wait_inc, wait_clear, wait_expired;

  assign op = 6'(opCode);
  assign fn = 6'(func);

  assign is_jump   = (op == OP_J) || (op == OP_JAL) || ((op == OP_R) && (fn == FUNC_JR));
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BGTZ);
  assign is_lw     = (op == OP_LW);
  assign is_sw     = (op == OP_SW);

`ifdef MC_SEQ_TRAP_EN
  assign trap_illegal = !is_legal_op(op);
`else
  assign trap_illegal = 1'b0;
`endif

  // Wait cycles are counted here rather than in the FSM block so the timer's
  // expired output does not feed back into the process that generates inc.
  assign wait_inc   = ((state_q == S_IF) && !imem_ready) ||
                      ((state_q == S_MEM) && !dmem_ready);
  assign wait_clear = (next_state != state_q);

  mc_wait_timer #(.TIMEOUT_W(TIMEOUT_W)) u_wait_timer (
    .CLK     (CLK),
    .nRST    (nRST),
    .inc     (wait_inc),
    .clear   (wait_clear),
    .hold    (stall),
    .expired (wait_expired)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= S_IF;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= next_state;
      err_q   <= next_err;
    end
  end

  always_comb begin
    next_state = state_q;
    next_err   = err_q;
    imem_req   = 1'b0;
    IRWrite    = 1'b0;
    pcWrite    = 1'b0;
    RegWr      = 1'b0;
    nRD        = 1'b1;
    nWR        = 1'b1;
    case (state_q)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWrite    = 1'b1;
          next_state = S_ID;
        end else if (wait_expired) begin
          next_state = S_ERR;
          next_err   = ERR_TIMEOUT;
        end
      end
      S_ID: begin
        if (is_jump) begin
          pcWrite    = 1'b1;
          RegWr      = (op == OP_JAL);
          next_state = S_IF;
        end else if (op == OP_HALT) begin
          next_state = S_HALT;
        end else if (trap_illegal) begin
          next_state = S_ERR;
          next_err   = ERR_ILLEGAL;
        end else begin
          next_state = S_EXE;
        end
      end
      S_EXE: begin
        if (is_branch) begin
          pcWrite    = 1'b1;
          next_state = S_IF;
        end else if (is_lw || is_sw) begin
          next_state = S_MEM;
        end else begin
          next_state = S_WB;
        end
      end
      S_MEM: begin
        nRD = !is_lw;
        nWR = !is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            pcWrite    = 1'b1;
            next_state = S_IF;
          end else begin
            next_state = S_WB;
          end
        end else if (wait_expired) begin
          next_state = S_ERR;
          next_err   = ERR_TIMEOUT;
        end
      end
      S_WB: begin
        RegWr      = 1'b1;
        pcWrite    = 1'b1;
        next_state = S_IF;
      end
      S_HALT:  next_state = S_HALT;
      S_ERR:   next_state = S_ERR;
      default: next_state = S_ERR;
    endcase
    // Stall freezes progress and the commit strobes; request/read/write
    // levels stay as the state dictates so the memory side sees no glitch.
    if (stall) begin
      next_state = state_q;
      next_err   = err_q;
      IRWrite    = 1'b0;
      pcWrite    = 1'b0;
      RegWr      = 1'b0;
    end
  end

  assign state    = state_q;
  assign halted   = (state_q == S_HALT);
  assign err      = (state_q == S_ERR);
  assign err_code = err_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// tb_mc_sequencer: self-checking bench for mc_sequencer. Expected per-cycle
// traces are built from the instruction class (phase list with inserted wait
// and stall cycles); a second instance with TIMEOUT_W = 2 covers the timeout.
module tb_mc_sequencer;

  localparam int W = 13;

  localparam logic [2:0] ST_IF = 3'b000, ST_ID = 3'b001, ST_EXE = 3'b010, ST_MEM = 3'b011,
                         ST_WB = 3'b100, ST_HALT = 3'b101, ST_ERR = 3'b111;

  localparam logic [5:0] R_OP = 6'b000000, JR_FN = 6'b001000, ADD_FN = 6'b100000;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, ORI = 6'b001101;
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, BGTZ = 6'b000111;
  localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, HALT = 6'b111111;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       nRST;
  logic [5:0] opCode, func;
  logic       imem_ready, dmem_ready, stall;
  logic [2:0] state;
  logic       imem_req, IRWrite, pcWrite, RegWr, nRD, nWR, halted, err;
  logic [1:0] err_code;

  mc_sequencer dut (
    .CLK(CLK), .nRST(nRST), .opCode(opCode), .func(func),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .stall(stall),
    .state(state), .imem_req(imem_req), .IRWrite(IRWrite), .pcWrite(pcWrite),
    .RegWr(RegWr), .nRD(nRD), .nWR(nWR), .halted(halted), .err(err), .err_code(err_code)
  );

  logic       t_nRST;
  logic [5:0] t_opCode, t_func;
  logic       t_imem_ready, t_dmem_ready, t_stall;
  logic [2:0] t_state;
  logic       t_imem_req, t_IRWrite, t_pcWrite, t_RegWr, t_nRD, t_nWR, t_halted, t_err;
  logic [1:0] t_err_code;

  mc_sequencer #(.TIMEOUT_W(2)) dut_t (
    .CLK(CLK), .nRST(t_nRST), .opCode(t_opCode), .func(t_func),
    .imem_ready(t_imem_ready), .dmem_ready(t_dmem_ready), .stall(t_stall),
    .state(t_state), .imem_req(t_imem_req), .IRWrite(t_IRWrite), .pcWrite(t_pcWrite),
    .RegWr(t_RegWr), .nRD(t_nRD), .nWR(t_nWR), .halted(t_halted), .err(t_err),
    .err_code(t_err_code)
  );

  // ---------------- scoreboard ----------------
  // record: {state[3], imem_req, IRWrite, pcWrite, RegWr, nRD, nWR, halted, err, err_code[2]}
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  logic [14:0]   stim_q[$];  // {opCode, func, stall, imem_ready, dmem_ready}
  logic [5:0]    cur_op, cur_fn;
  int errors = 0;
  int checks = 0;

  function automatic logic [W-1:0] rec(input logic [2:0] st, input logic ireq, input logic irw,
                                       input logic pcw, input logic rw, input logic nrd,
                                       input logic nwr, input logic [1:0] ec);
    rec = {st, ireq, irw, pcw, rw, nrd, nwr, (st == ST_HALT), (st == ST_ERR), ec};
  endfunction

  // Same cycle with the commit strobes (IRWrite, pcWrite, RegWr) suppressed.
  function automatic logic [W-1:0] quiet(input logic [W-1:0] r);
    logic [W-1:0] m;
    m = 13'h1C0;
    quiet = r & ~m;
  endfunction

  function automatic logic [W-1:0] sample_main();
    sample_main = {state, imem_req, IRWrite, pcWrite, RegWr, nRD, nWR, halted, err, err_code};
  endfunction

  task automatic push(input logic [2:0] s, input logic [W-1:0] e);
    stim_q.push_back({cur_op, cur_fn, s});
    exp_q.push_back(e);
  endtask

  task automatic clear_queues();
    stim_q.delete();
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic stall_pad(input int ph, input int st_ph, input int st_len, input logic [W-1:0] e);
    if (ph == st_ph) begin
      for (int k = 0; k < st_len; k++)
        push({1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))}, quiet(e));
    end
  endtask

  // Build the expected cycle trace of one instruction. Phases: 0 IF, 1 ID,
  // 2 EXE, 3 MEM, 4 WB; st_len stall cycles are inserted at the start of st_ph.
  task automatic gen_instr(input logic [5:0] op, input logic [5:0] fn, input int w_if,
                           input int w_mem, input int st_ph, input int st_len);
    logic is_j, is_jal, is_br, is_lw, is_sw, illegal;
    logic [W-1:0] e, e_wait;
    cur_op  = op;
    cur_fn  = fn;
    is_jal  = (op == JAL);
    is_j    = (op == J) || is_jal || (op == R_OP && fn == JR_FN);
    is_br   = (op == BEQ) || (op == BNE) || (op == BGTZ);
    is_lw   = (op == LW);
    is_sw   = (op == SW);
    illegal = !(op inside {R_OP, ADDI, SLTI, ORI, LW, SW, BEQ, BNE, BGTZ, J, JAL, HALT});
    // fetch
    e = rec(ST_IF, 1, 0, 0, 0, 1, 1, 2'b00);
    stall_pad(0, st_ph, st_len, e);
    for (int k = 0; k < w_if; k++) push(3'b000, e);
    push(3'b010, rec(ST_IF, 1, 1, 0, 0, 1, 1, 2'b00));
    // decode
    e = is_j ? rec(ST_ID, 0, 0, 1, is_jal, 1, 1, 2'b00) : rec(ST_ID, 0, 0, 0, 0, 1, 1, 2'b00);
    stall_pad(1, st_ph, st_len, e);
    push(3'b000, e);
    if (is_j || op == HALT) return;
`ifdef MC_SEQ_TRAP_EN
    if (illegal) begin
      for (int k = 0; k < 3; k++) push(3'b010, rec(ST_ERR, 0, 0, 0, 0, 1, 1, 2'b10));
      return;
    end
`else
    if (illegal) cur_fn = fn;
`endif
    // execute
    e = is_br ? rec(ST_EXE, 0, 0, 1, 0, 1, 1, 2'b00) : rec(ST_EXE, 0, 0, 0, 0, 1, 1, 2'b00);
    stall_pad(2, st_ph, st_len, e);
    push(3'b000, e);
    if (is_br) return;
    // memory
    if (is_lw || is_sw) begin
      e_wait = rec(ST_MEM, 0, 0, 0, 0, !is_lw, !is_sw, 2'b00);
      stall_pad(3, st_ph, st_len, e_wait);
      for (int k = 0; k < w_mem; k++) push(3'b000, e_wait);
      push(3'b001, is_sw ? rec(ST_MEM, 0, 0, 1, 0, 1, 0, 2'b00) : e_wait);
      if (is_sw) return;
    end
    // write back
    e = rec(ST_WB, 0, 0, 1, 1, 1, 1, 2'b00);
    stall_pad(4, st_ph, st_len, e);
    push(3'b000, e);
  endtask

  // ---------------- drivers ----------------
  // Entered and left just after a rising edge; samples at the falling edge.
  task automatic drive_queue();
    logic [14:0] s;
    obs_q.delete();
    for (int i = 0; i < stim_q.size(); i++) begin
      s = stim_q[i];
      opCode = s[14:9]; func = s[8:3]; stall = s[2]; imem_ready = s[1]; dmem_ready = s[0];
      @(negedge CLK);
      obs_q.push_back(sample_main());
      @(posedge CLK); #1;
    end
  endtask

  // Release with stall high so the first edge after reset leaves the counter at 0.
  task automatic do_reset();
    nRST = 1'b0; stall = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    opCode = R_OP; func = ADD_FN;
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic t_reset();
    t_nRST = 1'b0; t_stall = 1'b1; t_imem_ready = 1'b0; t_dmem_ready = 1'b0;
    t_opCode = R_OP; t_func = ADD_FN;
    repeat (2) @(negedge CLK);
    t_nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic t_cycle(input logic s, input logic r);
    t_stall = s; t_imem_ready = r;
    @(posedge CLK); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    e = rec(ST_IF, 1, 0, 0, 0, 1, 1, 2'b00);
    nRST = 1'b0; stall = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    opCode = LW; func = 6'd0;
    @(negedge CLK);
    checks++;
    if (sample_main() !== e) begin
      errors++; $display("FAIL reset_hold got=%h exp=%h", sample_main(), e);
    end
    do_reset();
    checks++;
    if (sample_main() !== e) begin
      errors++; $display("FAIL reset_release got=%h exp=%h", sample_main(), e);
    end
  endtask

  task automatic test_alu();
    clear_queues();
    gen_instr(R_OP, ADD_FN, 0, 0, -1, 0);
    gen_instr(ADDI, 6'd3, 2, 0, -1, 0);
    gen_instr(ORI, 6'd0, 0, 0, 0, 2);
    gen_instr(SLTI, 6'd9, 1, 0, 4, 3);
    drive_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL alu cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mem_wait();
    clear_queues();
    gen_instr(LW, 6'd0, 0, 3, -1, 0);
    gen_instr(SW, 6'd0, 0, 0, -1, 0);
    gen_instr(SW, 6'd0, 1, 4, 3, 2);
    gen_instr(LW, 6'd0, 0, 0, 3, 1);
    drive_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL mem_wait cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch_stall();
    clear_queues();
    gen_instr(BEQ, 6'd0, 0, 0, 2, 5);
    gen_instr(BNE, 6'd0, 0, 0, -1, 0);
    gen_instr(BGTZ, 6'd0, 1, 0, 1, 2);
    drive_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL branch_stall cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_jumps();
    clear_queues();
    gen_instr(JAL, 6'd0, 0, 0, -1, 0);
    gen_instr(J, 6'd0, 0, 0, -1, 0);
    gen_instr(R_OP, JR_FN, 1, 0, 1, 2);
    drive_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL jumps cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] ops [11];
    logic [5:0] op, fn;
    int st_ph, st_len;
    ops = '{R_OP, ADDI, SLTI, ORI, LW, SW, BEQ, BNE, BGTZ, J, JAL};
    clear_queues();
    for (int n = 0; n < 30; n++) begin
      op = ops[$urandom_range(0, 10)];
      fn = ($urandom_range(0, 2) == 0) ? JR_FN : 6'($urandom_range(0, 63));
      st_ph  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 4)) : -1;
      st_len = int'($urandom_range(1, 3));
      gen_instr(op, fn, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), st_ph, st_len);
    end
    drive_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL back_to_back cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    clear_queues();
    cur_op = LW; cur_fn = 6'd0;
    push(3'b010, rec(ST_IF, 1, 1, 0, 0, 1, 1, 2'b00));
    push(3'b000, rec(ST_ID, 0, 0, 0, 0, 1, 1, 2'b00));
    push(3'b000, rec(ST_EXE, 0, 0, 0, 0, 1, 1, 2'b00));
    push(3'b000, rec(ST_MEM, 0, 0, 0, 0, 0, 1, 2'b00));
    push(3'b000, rec(ST_MEM, 0, 0, 0, 0, 0, 1, 2'b00));
    drive_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL async_pre cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    #2 nRST = 1'b0;
    #1;
    checks++;
    if ({state, imem_req, nRD, nWR} !== {ST_IF, 3'b111}) begin
      errors++; $display("FAIL async_reset got=%b exp=%b", {state, imem_req, nRD, nWR}, {ST_IF, 3'b111});
    end
    do_reset();
  endtask

  task automatic test_illegal();
    clear_queues();
    gen_instr(6'b111110, 6'd0, 0, 0, -1, 0);
    drive_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
    do_reset();
  endtask

  task automatic test_halt();
    clear_queues();
    gen_instr(HALT, 6'd0, 1, 0, -1, 0);
    for (int k = 0; k < 21; k++)
      push({1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))},
           rec(ST_HALT, 0, 0, 0, 0, 1, 1, 2'b00));
    drive_queue();
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL halt cyc%0d got=%h exp=%h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_timeout();
    // three not-ready fetch cycles exhaust a 2-bit timer
    t_reset();
    for (int k = 0; k < 3; k++) begin
      t_cycle(1'b0, 1'b0);
      checks++;
      if (t_state !== ((k < 2) ? ST_IF : ST_ERR)) begin
        errors++; $display("FAIL timeout_step%0d got=%b exp=%b", k, t_state, (k < 2) ? ST_IF : ST_ERR);
      end
    end
    checks++;
    if ({t_err, t_err_code, t_imem_req} !== 4'b1010) begin
      errors++; $display("FAIL timeout_flags got=%b exp=1010", {t_err, t_err_code, t_imem_req});
    end
    repeat (10) t_cycle(1'b0, 1'b1);
    checks++;
    if ({t_state, t_err, t_err_code} !== {ST_ERR, 3'b101}) begin
      errors++; $display("FAIL timeout_sticky got=%b exp=%b", {t_state, t_err, t_err_code}, {ST_ERR, 3'b101});
    end
    @(negedge CLK); #2 t_nRST = 1'b0; #1;
    checks++;
    if ({t_state, t_err, t_err_code, t_imem_req} !== {ST_IF, 4'b0001}) begin
      errors++; $display("FAIL timeout_reset got=%b exp=%b", {t_state, t_err, t_err_code, t_imem_req}, {ST_IF, 4'b0001});
    end
    // ready in the last tolerated cycle wins
    t_reset();
    t_cycle(1'b0, 1'b0);
    t_cycle(1'b0, 1'b0);
    t_cycle(1'b0, 1'b1);
    checks++;
    if ({t_state, t_err} !== {ST_ID, 1'b0}) begin
      errors++; $display("FAIL timeout_ready_wins got=%b exp=%b", {t_state, t_err}, {ST_ID, 1'b0});
    end
    // stall freezes the count
    t_reset();
    t_cycle(1'b0, 1'b0);
    t_cycle(1'b0, 1'b0);
    repeat (3) t_cycle(1'b1, 1'b0);
    checks++;
    if (t_state !== ST_IF) begin
      errors++; $display("FAIL timeout_stall_hold got=%b exp=%b", t_state, ST_IF);
    end
    t_cycle(1'b0, 1'b0);
    checks++;
    if ({t_state, t_err_code} !== {ST_ERR, 2'b01}) begin
      errors++; $display("FAIL timeout_after_stall got=%b exp=%b", {t_state, t_err_code}, {ST_ERR, 2'b01});
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    t_nRST = 1'b0; t_stall = 1'b1; t_imem_ready = 1'b0; t_dmem_ready = 1'b0;
    t_opCode = R_OP; t_func = ADD_FN;
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch_stall();
    test_jumps();
    test_back_to_back();
    test_async_reset();
    test_illegal();
    test_halt();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
